data_cache_ctrl: RTL

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

---
 rtl/data_cache_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/data_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_ctrl
// Purpose  : Direct-mapped, write-through, write-allocate data cache
//            controller for the M pipeline stage. It has 16 lines of 4 words.
//            Hits are resolved combinationally in IDLE. A miss refills the
//            whole line from backing memory, one word read per cycle, and
//            holds hit low for exactly 5 cycles.
// Ports    : CLK, CLR            - clock, synchronous active-high reset
//            MemtoRegM/MemWriteM - load / store request (load wins if both)
//            ALUOutM, WriteDataM - byte address, store data
//            ReadDataM, hit      - load data, access-complete flag
//            mem_rd/mem_wr       - backing read request / write-through store
//            mem_addr/mem_wdata  - shared address, store data
//            mem_rdata           - read data, one cycle after mem_rd
//            hit_count/miss_count (only with CACHE_STATS_EN)
// Config   : `define CACHE_STATS_EN adds saturating hit/miss counters
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_ctrl (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        hit,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t      state;
  logic [2:0]  fill_cnt;   // 1..3 issue words 1..3; 4 = final capture cycle
  logic [23:0] fill_tag;
  logic [3:0]  fill_idx;
  logic [15:0] valid;
  logic [23:0] tag_mem  [16];
  logic [31:0] data_mem [16][4];

  logic [23:0] req_tag;
  logic [3:0]  req_idx;
  logic [1:0]  req_off;
  logic        access;
  logic        is_store;
  logic        tag_match;
  logic        in_idle;
  logic        idle_hit;
  logic        idle_miss;
  logic        fill_issue;

  assign req_tag    = ALUOutM[31:8];
  assign req_idx    = ALUOutM[7:4];
  assign req_off    = ALUOutM[3:2];
  assign access     = MemtoRegM | MemWriteM;
  assign is_store   = MemWriteM & ~MemtoRegM;
  assign tag_match  = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign in_idle    = (state == IDLE);
  assign idle_hit   = in_idle & access & tag_match;
  assign idle_miss  = in_idle & access & ~tag_match;
  assign fill_issue = (state == FILL) & ~fill_cnt[2];

  always_comb begin
    hit       = in_idle & (~access | tag_match);
    ReadDataM = (idle_hit & MemtoRegM) ? data_mem[req_idx][req_off] : 32'd0;
    mem_wr    = idle_hit & is_store;
    mem_wdata = mem_wr ? WriteDataM : 32'd0;
    mem_rd    = idle_miss | fill_issue;
    mem_addr  = 32'd0;
    if (idle_miss)
      mem_addr = {req_tag, req_idx, 4'b0000};
    else if (fill_issue)
      mem_addr = {fill_tag, fill_idx, fill_cnt[1:0], 2'b00};
    else if (mem_wr)
      mem_addr = ALUOutM;
  end

  // Control state: the refill target is latched at miss detection so that
  // address changes during FILL cannot redirect the refill.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      fill_cnt <= 3'd0;
      fill_tag <= 24'd0;
      fill_idx <= 4'd0;
      valid    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_miss) begin
            state    <= FILL;
            fill_cnt <= 3'd1;
            fill_tag <= req_tag;
            fill_idx <= req_idx;
          end
        end
        FILL: begin
          if (fill_cnt[2]) begin
            state           <= IDLE;
            fill_cnt        <= 3'd0;
            valid[fill_idx] <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage arrays are not reset; validity alone governs hits.
  // In FILL, mem_rdata carries the word issued on the previous cycle,
  // i.e. word (fill_cnt - 1); the 2-bit wrap maps count 4 to word 3.
  always_ff @(posedge CLK) begin
    if (mem_wr)
      data_mem[req_idx][req_off] <= WriteDataM;
    if (state == FILL)
      data_mem[fill_idx][fill_cnt[1:0] - 2'd1] <= mem_rdata;
    if ((state == FILL) && fill_cnt[2])
      tag_mem[fill_idx] <= fill_tag;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (idle_hit && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (idle_miss && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
